// File: rtl/read_batch_loader.sv
// Batch line-fetch engine: issues 4 line requests per read, bounded by an
// outstanding-request limit, and forwards in-order responses to the read RAM stage.
module read_batch_loader #(
  parameter int CL              = 512,
  parameter int MAX_READ        = 256,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [8:0]            batch_size_in,
  output logic                  rd_req_valid,
  output logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic                  rd_req_ready,
  input  logic                  rd_rsp_valid,
  input  logic [CL-1:0]         rd_rsp_data,
  output logic                  load_valid,
  output logic [CL-1:0]         load_data,
  output logic [8:0]            batch_size,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] OUT_LIMIT = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0] OUT_ONE   = OW'(1);
  localparam logic [9:0]    MAX_SIZE  = 10'(MAX_READ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic [8:0]              size_r;
  logic [10:0]             req_cnt_r, rsp_cnt_r, total_s;
  logic [OW-1:0]           out_r;
  logic                    load_valid_r, busy_r, done_r, error_r;
  logic [CL-1:0]           load_data_r;
  logic                    size_bad_s, issue_s, accept_s, active_s, rsp_in_s, req_last_s;

  assign total_s    = {size_r, 2'b00};
  assign size_bad_s = (size_r == 9'd0) || ({1'b0, size_r} > MAX_SIZE);
  assign accept_s   = (state_r == IDLE) && start;
  assign active_s   = (state_r == REQ) || (state_r == DRAIN);
  assign rsp_in_s   = rd_rsp_valid && active_s;
  assign issue_s    = rd_req_valid && rd_req_ready;
  assign req_last_s = (req_cnt_r == (total_s - 11'd1));

  // Request channel is driven purely from registered state, so it cannot move while stalled.
  always_comb begin
    rd_req_valid = 1'b0;
    rd_req_addr  = base_r + ADDR_WIDTH'(req_cnt_r);
    if ((state_r == REQ) && !size_bad_s && (req_cnt_r < total_s) && (out_r < OUT_LIMIT)) begin
      rd_req_valid = 1'b1;
    end else begin
      rd_req_valid = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = REQ; else state_s = IDLE;
      REQ: begin
        if (size_bad_s)                   state_s = FIN;
        else if (issue_s && req_last_s)   state_s = DRAIN;
        else                              state_s = REQ;
      end
      DRAIN:   if (rsp_cnt_r == total_s) state_s = FIN; else state_s = DRAIN;
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == REQ) || (state_s == DRAIN);
      done_r  <= (state_s == FIN);
    end
  end

  // Batch parameters, counters, response forwarding and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_r       <= {ADDR_WIDTH{1'b0}};
      size_r       <= 9'd0;
      req_cnt_r    <= 11'd0;
      rsp_cnt_r    <= 11'd0;
      out_r        <= {OW{1'b0}};
      load_valid_r <= 1'b0;
      load_data_r  <= {CL{1'b0}};
      error_r      <= 1'b0;
    end else begin
      load_valid_r <= rsp_in_s;
      if (rsp_in_s) load_data_r <= rd_rsp_data;
      if (accept_s) begin
        base_r    <= base_addr;
        size_r    <= batch_size_in;
        req_cnt_r <= 11'd0;
        rsp_cnt_r <= 11'd0;
        out_r     <= {OW{1'b0}};
      end else begin
        if (issue_s)  req_cnt_r <= req_cnt_r + 11'd1;
        if (rsp_in_s) rsp_cnt_r <= rsp_cnt_r + 11'd1;
        case ({issue_s, rsp_in_s})
          2'b10:   out_r <= out_r + OUT_ONE;
          2'b01:   out_r <= out_r - OUT_ONE;
          default: out_r <= out_r;
        endcase
      end
      // A stray response outranks the clear from a simultaneous start.
      if (rd_rsp_valid && !active_s)            error_r <= 1'b1;
      else if ((state_r == REQ) && size_bad_s)  error_r <= 1'b1;
      else if (accept_s)                        error_r <= 1'b0;
      else                                      error_r <= error_r;
    end
  end

  assign load_valid = load_valid_r;
  assign load_data  = load_data_r;
  assign batch_size = size_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule

// File: tb/tb_read_batch_loader.sv
// Directed self-checking bench for read_batch_loader: a memory model answers
// requests in order after a fixed latency, and each scenario checks its own results.
module tb_read_batch_loader;
  localparam int CL = 512;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset_n, start, rd_req_valid, rd_req_ready, rd_rsp_valid;
  logic [AW-1:0] base_addr, rd_req_addr;
  logic [8:0]    batch_size_in, batch_size;
  logic [CL-1:0] rd_rsp_data, load_data;
  logic          load_valid, busy, done, error;

  always #5 clk = ~clk;

  read_batch_loader #(.CL(CL), .MAX_READ(256), .MAX_OUTSTANDING(8), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .batch_size_in(batch_size_in), .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
    .rd_req_ready(rd_req_ready), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .load_valid(load_valid), .load_data(load_data), .batch_size(batch_size),
    .busy(busy), .done(done), .error(error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int lat = 2;
  bit ready_toggle = 1'b0;
  bit hold_mode = 1'b0;
  bit pulse_start = 1'b0;
  logic [31:0] req_q[$];
  logic [31:0] beat_q[$];
  logic [31:0] pend_q[$];
  int          due_q[$];
  int cur_out, max_out, done_cnt, done_cyc, last_beat_cyc, start_cyc;
  bit stall_bad, prev_stall, seen_valid;
  logic [31:0] prev_addr;

  task automatic clr();
    req_q.delete(); beat_q.delete(); pend_q.delete(); due_q.delete();
    cur_out = 0; max_out = 0; done_cnt = 0; done_cyc = -1; last_beat_cyc = -1;
    start_cyc = -1; stall_bad = 1'b0; prev_stall = 1'b0; seen_valid = 1'b0;
  endtask

  // One clock of bench activity: observe outputs, then drive inputs for the next edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (load_valid) begin beat_q.push_back(load_data[31:0]); last_beat_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (rd_req_valid) seen_valid = 1'b1;
    if (prev_stall && (!rd_req_valid || rd_req_addr !== prev_addr)) stall_bad = 1'b1;
    start = pulse_start;
    if (pulse_start) start_cyc = cyc;
    pulse_start = 1'b0;
    rd_req_ready = ready_toggle ? cyc[0] : 1'b1;
    if (rd_req_valid && rd_req_ready) begin
      req_q.push_back(rd_req_addr);
      pend_q.push_back(rd_req_addr);
      due_q.push_back(cyc + lat);
      cur_out++;
    end
    prev_stall = rd_req_valid && !rd_req_ready;
    prev_addr  = rd_req_addr;
    rd_rsp_valid = 1'b0;
    if (!(hold_mode && ((cyc % 40) < 24)) && pend_q.size() > 0 && due_q[0] <= cyc) begin
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = {16{pend_q.pop_front()}};
      void'(due_q.pop_front());
      cur_out--;
    end
    if (cur_out > max_out) max_out = cur_out;
  endtask

  task automatic run_batch(input logic [31:0] base, input logic [8:0] sz, input int budget);
    clr();
    base_addr = base; batch_size_in = sz; pulse_start = 1'b1;
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; rd_req_ready = 1'b1; rd_rsp_valid = 1'b0;
    rd_rsp_data = {CL{1'b0}}; base_addr = 32'h0; batch_size_in = 9'd0;
    repeat (3) @(negedge clk);
    n_tests++; if ({rd_req_valid, load_valid, busy, done, error} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 00000", {rd_req_valid, load_valid, busy, done, error}); end
    n_tests++; if (batch_size !== 9'd0) begin
      n_fail++; $display("FAIL reset_batch_size got %0d want 0", batch_size); end
    n_tests++; if (load_data !== {CL{1'b0}}) begin
      n_fail++; $display("FAIL reset_load_data got %h want 0", load_data[31:0]); end
    reset_n = 1'b1;
    repeat (2) tick();
    n_tests++; if ({busy, done, error} !== 3'b0) begin
      n_fail++; $display("FAIL idle_after_reset got %b want 000", {busy, done, error}); end
  endtask

  task automatic test_basic();
    logic [31:0] exp;
    bit addr_ok, data_ok;
    lat = 2; ready_toggle = 1'b0; hold_mode = 1'b0;
    clr();
    base_addr = 32'h100; batch_size_in = 9'd2; pulse_start = 1'b1;
    tick(); tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
    for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
    repeat (4) tick();
    addr_ok = (req_q.size() == 8); data_ok = (beat_q.size() == 8);
    for (int i = 0; i < 8; i++) begin
      exp = 32'h100 + i;
      if (addr_ok && req_q[i] !== exp) addr_ok = 1'b0;
      if (data_ok && beat_q[i] !== exp) data_ok = 1'b0;
    end
    n_tests++; if (!addr_ok) begin n_fail++; $display("FAIL basic_addrs got %0d reqs want 8 at 0x100..0x107", req_q.size()); end
    n_tests++; if (!data_ok) begin n_fail++; $display("FAIL basic_beats got %0d beats want 8 in order", beat_q.size()); end
    n_tests++; if (done_cnt !== 1 || done_cyc !== last_beat_cyc + 1) begin
      n_fail++; $display("FAIL basic_done got cnt=%0d at %0d want 1 at %0d", done_cnt, done_cyc, last_beat_cyc + 1); end
    n_tests++; if (error !== 1'b0 || batch_size !== 9'd2 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_status got err=%b size=%0d busy=%b want 0 2 0", error, batch_size, busy); end
  endtask

  task automatic test_big();
    bit ok;
    lat = 2; ready_toggle = 1'b1; hold_mode = 1'b1;
    run_batch(32'h2000, 9'd256, 20000);
    ok = (beat_q.size() == 1024) && (req_q.size() == 1024);
    for (int i = 0; ok && i < 1024; i++)
      if (req_q[i] !== 32'h2000 + i || beat_q[i] !== 32'h2000 + i) ok = 1'b0;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL big_stream got %0d reqs %0d beats want 1024 in order", req_q.size(), beat_q.size()); end
    n_tests++; if (max_out !== 8) begin n_fail++; $display("FAIL big_outstanding got max %0d want 8", max_out); end
    n_tests++; if (stall_bad) begin n_fail++; $display("FAIL big_stall_stable got unstable want stable"); end
    n_tests++; if (done_cnt !== 1 || error !== 1'b0) begin
      n_fail++; $display("FAIL big_done got cnt=%0d err=%b want 1 0", done_cnt, error); end
    ready_toggle = 1'b0; hold_mode = 1'b0;
  endtask

  task automatic test_wrap();
    lat = 2;
    run_batch(32'hFFFF_FFFE, 9'd1, 200);
    n_tests++; if (req_q.size() != 4 || req_q[0] !== 32'hFFFF_FFFE || req_q[1] !== 32'hFFFF_FFFF ||
                   req_q[2] !== 32'h0000_0000 || req_q[3] !== 32'h0000_0001) begin
      n_fail++; $display("FAIL wrap_addrs got %0d reqs first %h last %h want FFFFFFFE..00000001",
                         req_q.size(), (req_q.size() > 0) ? req_q[0] : 32'hx, (req_q.size() > 3) ? req_q[3] : 32'hx);
    end
  endtask

  task automatic test_bad_size();
    logic [8:0] sizes [2];
    sizes[0] = 9'd0; sizes[1] = 9'd300;
    for (int k = 0; k < 2; k++) begin
      clr();
      base_addr = 32'h500; batch_size_in = sizes[k]; pulse_start = 1'b1;
      tick(); tick();
      n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL bad%0d_err_cleared got %b want 0", k, error); end
      for (int i = 0; i < 50 && done_cnt == 0; i++) tick();
      repeat (3) tick();
      n_tests++; if (seen_valid) begin n_fail++; $display("FAIL bad%0d_no_req got valid want none", k); end
      n_tests++; if (error !== 1'b1 || batch_size !== sizes[k]) begin
        n_fail++; $display("FAIL bad%0d_status got err=%b size=%0d want 1 %0d", k, error, batch_size, sizes[k]); end
      n_tests++; if (done_cnt !== 1 || done_cyc !== start_cyc + 2) begin
        n_fail++; $display("FAIL bad%0d_done got cnt=%0d at +%0d want 1 at +2", k, done_cnt, done_cyc - start_cyc); end
    end
  endtask

  task automatic test_reset_mid();
    lat = 2;
    clr();
    base_addr = 32'h40; batch_size_in = 9'd4; pulse_start = 1'b1;
    for (int i = 0; i < 200 && beat_q.size() < 5; i++) tick();
    n_tests++; if (beat_q.size() != 5 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_progress got beats=%0d busy=%b want 5 1", beat_q.size(), busy); end
    @(negedge clk);
    reset_n = 1'b0; rd_rsp_valid = 1'b0;
    #1;
    n_tests++; if ({rd_req_valid, load_valid, busy, done, error} !== 5'b0 || batch_size !== 9'd0 || load_data !== {CL{1'b0}}) begin
      n_fail++; $display("FAIL mid_reset_outputs got %b size=%0d want all 0", {rd_req_valid, load_valid, busy, done, error}, batch_size); end
    @(negedge clk); reset_n = 1'b1;
    pend_q.delete(); due_q.delete(); cur_out = 0;
    @(negedge clk); rd_rsp_valid = 1'b1; rd_rsp_data = {16{32'h45}};
    @(negedge clk); rd_rsp_valid = 1'b0;
    n_tests++; if (load_valid !== 1'b0 || error !== 1'b1) begin
      n_fail++; $display("FAIL mid_spurious got lv=%b err=%b want 0 1", load_valid, error); end
  endtask

  task automatic test_restart_drain();
    lat = 6;
    clr();
    base_addr = 32'h300; batch_size_in = 9'd2; pulse_start = 1'b1;
    for (int i = 0; i < 100 && req_q.size() < 8; i++) tick();
    tick();
    base_addr = 32'h999; batch_size_in = 9'd5; pulse_start = 1'b1;
    for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
    repeat (10) tick();
    n_tests++; if (batch_size !== 9'd2 || error !== 1'b0) begin
      n_fail++; $display("FAIL drain_batch_size got %0d err=%b want 2 0", batch_size, error); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL drain_done_once got %0d want 1", done_cnt); end
    n_tests++; if (req_q.size() != 8 || beat_q.size() != 8 || req_q[7] !== 32'h307) begin
      n_fail++; $display("FAIL drain_counts got reqs=%0d beats=%0d want 8 8", req_q.size(), beat_q.size()); end
    lat = 2;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_big();
    test_wrap();
    test_bad_size();
    test_reset_mid();
    test_restart_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/read_batch_loader.md
READ_BATCH_LOADER -- requirements
Module: read_batch_loader

Interface
REQ-001 SHALL have parameter CL, default 512, cache-line width in bits.
REQ-002 SHALL have parameter MAX_READ, default 256, largest legal batch in reads.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 8, limit on issued-but-unanswered line requests.
REQ-004 SHALL have parameter ADDR_WIDTH, default 32, line-address width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, one-cycle batch launch pulse.
REQ-008 SHALL have port base_addr, input, ADDR_WIDTH, first line address of batch, sampled on accepted start.
REQ-009 SHALL have port batch_size_in, input, 9, read count, sampled on accepted start.
REQ-010 SHALL have ports rd_req_valid (output, 1), rd_req_addr (output, ADDR_WIDTH), rd_req_ready (input, 1): memory line-request handshake.
REQ-011 SHALL have ports rd_rsp_valid (input, 1), rd_rsp_data (input, CL): in-order line responses, no backpressure.
REQ-012 SHALL have ports load_valid (output, 1), load_data (output, CL), batch_size (output, 9): stream into the read RAM stage.
REQ-013 SHALL have ports busy (output, 1), done (output, 1 pulse), error (output, 1 sticky).

Function
REQ-014 SHALL implement states IDLE, REQ, DRAIN, FIN.
REQ-015 SHALL in IDLE accept start, latch base_addr, batch_size_in, clear counters and error, and go to REQ next cycle.
REQ-016 SHALL, if latched size is 0 or exceeds MAX_READ, issue no requests, set error, go to FIN.
REQ-017 SHALL compute total_lines = 4 x size (11 bits); each read is four lines in order: read part 1, read part 2, params, ik.
REQ-018 SHALL in REQ assert rd_req_valid when req_cnt < total_lines and outstanding < MAX_OUTSTANDING; rd_req_addr = base_addr + req_cnt, wrapping mod 2^ADDR_WIDTH.
REQ-019 SHALL keep rd_req_valid and rd_req_addr stable while rd_req_ready is low; a request counts only on valid and ready both high.
REQ-020 SHALL increment outstanding on issue, decrement on rd_rsp_valid, leave it unchanged when both occur in the same cycle.
REQ-021 SHALL move REQ to DRAIN on the cycle the last request is issued.
REQ-022 SHALL register every response while busy: load_valid and load_data follow rd_rsp_valid and rd_rsp_data by exactly one cycle; rsp_cnt increments per response.
REQ-023 SHALL move DRAIN to FIN when rsp_cnt reaches total_lines.
REQ-024 SHALL in FIN pulse done for one cycle and return to IDLE; busy is high in REQ and DRAIN only.
REQ-025 SHALL drive batch_size with the latched size from start acceptance until the next accepted start.
REQ-026 SHALL ignore start while busy or in FIN.
REQ-027 SHALL discard a response in IDLE or FIN (load_valid stays 0) and set error.
REQ-028 SHALL hold error until the next accepted start or reset.

Reset
REQ-029 SHALL on reset_n low immediately go to IDLE and zero all counters, rd_req_valid, load_valid, load_data, batch_size, busy, done and error, including mid-batch; later responses from the aborted batch are discarded with error set.

Verification
REQ-030 SHALL cover a batch of size 2, base 0x100, ready always high, 2-cycle response latency -> addresses 0x100..0x107, eight load_valid beats in order, done one cycle after the eighth beat, error 0.
REQ-031 SHALL cover size 256 with rd_req_ready toggling every cycle and responses held back -> outstanding never exceeds 8, exactly 1024 beats, addresses stable while stalled.
REQ-032 SHALL cover base 0xFFFFFFFE with size 1 -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-033 SHALL cover size 0 and size 300 -> no rd_req_valid, error 1, done pulse two cycles after start.
REQ-034 SHALL cover reset_n low after 5 of 16 beats, then a spurious response -> all outputs 0 at once, response dropped, error 1.
REQ-035 SHALL cover start pulsed again during DRAIN -> ignored, batch_size unchanged, done pulses exactly once.
